// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_arbiter
// Purpose  : Round-robin arbiter/sequencer that lends one shared WIDTH-bit
//            up-counter to NREQ requesters. The winner's length is latched.
//            The counter is cleared for one cycle, then enabled until it
//            reaches that length. A one-cycle done pulse goes back to the
//            winner before arbitration resumes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock      in   1           system clock, rising edge
//   reset      in   1           asynchronous active-low reset
//   req        in   NREQ        request lines, one per requester
//   len        in   NREQ*WIDTH  packed lengths, requester i at [i*WIDTH +: WIDTH]
//   grant      out  NREQ        one-hot grant, held for the whole transaction
//   done       out  NREQ        one-cycle completion pulse to the winner
//   busy       out  1           high whenever the sequencer is not idle
//   cnt_clear  out  1           synchronous clear to the shared counter
//   cnt_enable out  1           count enable to the shared counter
//   cnt_value  in   WIDTH       current value of the shared counter
// ============================================================================
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  input  logic [WIDTH-1:0]      cnt_value
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [IW-1:0]    gsel;     // index of the current winner
  logic [IW-1:0]    ptr;      // index of the last completed winner
  logic [WIDTH-1:0] target;   // latched length of the current transaction

  logic [IW-1:0]    sel;
  logic             sel_valid;

  // Round-robin pick: the first set request at ptr+1, ptr+2, ... (mod NREQ).
  // The scan walks from the farthest candidate to the nearest so that the
  // nearest set request is the one left standing.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = ptr;
    sel_valid = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        sel       = idx[IW-1:0];
        sel_valid = 1'b1;
      end
    end
  end

  // Enable is decoded from registered state so it drops in the very cycle the
  // counter reaches target, leaving the counter parked at exactly target.
  assign cnt_enable = (state == RUN) && (cnt_value != target);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gsel      <= '0;
      ptr       <= IW'(NREQ - 1);   // requester 0 wins first after reset
      target    <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      cnt_clear <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (sel_valid) begin
            target    <= len[int'(sel)*WIDTH +: WIDTH];
            gsel      <= sel;
            grant     <= NREQ'(1) << sel;
            busy      <= 1'b1;
            cnt_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_clear <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          // A zero target is matched in the first RUN cycle, since the
          // counter was cleared on the CLEAR edge.
          if (cnt_value == target) begin
            done  <= NREQ'(1) << gsel;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= gsel;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`timescale 1ns/1ps
module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = '0;
  logic [15:0] len   = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        cnt_clear;
  logic        cnt_enable;
  logic [3:0]  cnt_value = '0;

  int tests = 0;
  int fails = 0;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .cnt_value  (cnt_value)
  );

  always #5 clock = ~clock;

  // Shared counter model: clear has priority over enable.
  always @(posedge clock) begin
    if (cnt_clear)       cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 4'd1;
  end

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  exp_grant;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  // One isolated transaction: req pulsed only until the grant appears.
  task automatic run_txn(input int k, input vec_t v);
    int en, gc, clr, dn, dpos, bm;
    logic [3:0] dval;
    logic [3:0] dcnt;
    en = 0; gc = 0; clr = 0; dn = 0; dpos = -1; bm = 0; dval = '0; dcnt = '0;
    @(posedge clock); #1;
    req = v.req;
    len = v.len;
    @(negedge clock);
    check($sformatf("t%0d_pre_grant", k), int'(grant), 0);
    @(negedge clock);
    check($sformatf("t%0d_grant", k), int'(grant), int'(v.exp_grant));
    req = '0;
    for (int c = 0; c < 40 && grant != 0; c++) begin
      gc++;
      if (cnt_enable) en++;
      if (cnt_clear) clr++;
      if (busy != (grant != 0)) bm++;
      if (done != 0) begin
        dn++;
        dval = done;
        dcnt = cnt_value;
        dpos = c;
      end
      @(negedge clock);
    end
    check($sformatf("t%0d_enables", k), en, v.exp_len);
    check($sformatf("t%0d_grant_cycles", k), gc, v.exp_len + 3);
    check($sformatf("t%0d_clear_cycles", k), clr, 1);
    check($sformatf("t%0d_done_pulses", k), dn, 1);
    check($sformatf("t%0d_done_bit", k), int'(dval), int'(v.exp_grant));
    check($sformatf("t%0d_cnt_at_done", k), int'(dcnt), v.exp_len);
    check($sformatf("t%0d_done_pos", k), dpos, v.exp_len + 2);
    check($sformatf("t%0d_busy_track", k), bm, 0);
    check($sformatf("t%0d_busy_after", k), int'(busy), 0);
  endtask

  initial begin
    logic [3:0] exp_rr[5];
    logic [3:0] prev_g;
    logic [3:0] dval;
    bit found;
    int ng, last_done, en, dn;

    // ---------------- reset state ----------------
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", int'({grant, done, busy, cnt_clear, cnt_enable}), 0);
    reset = 1'b1;

    // ---------------- table-driven transactions ----------------
    // len packs {len3, len2, len1, len0}; expectations follow round-robin
    // order starting with ptr = 3 after reset.
    vecs[0] = '{4'b0001, 16'h0005, 4'b0001, 5};   // single request, len 5
    vecs[1] = '{4'b0100, 16'h0000, 4'b0100, 0};   // zero length
    vecs[2] = '{4'b0010, 16'h00F0, 4'b0010, 15};  // maximum length, no wrap
    vecs[3] = '{4'b1111, 16'h1234, 4'b0100, 2};   // ptr=1 -> requester 2
    vecs[4] = '{4'b1001, 16'h7001, 4'b1000, 7};   // ptr=2 -> requester 3
    vecs[5] = '{4'b1001, 16'h7001, 4'b0001, 1};   // ptr=3 -> wraps to 0
    vecs[6] = '{4'b0110, 16'h0630, 4'b0010, 3};   // ptr=0 -> requester 1
    for (int k = 0; k < 7; k++) run_txn(k, vecs[k]);

    // ---------------- asynchronous reset mid-RUN ----------------
    @(posedge clock); #1;
    req = 4'b0001;
    len = 16'h0006;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (cnt_value == 4'd3 && cnt_enable) found = 1'b1;
    end
    check("reset_reach_run", int'(found), 1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({grant, done, busy, cnt_clear, cnt_enable}), 0);
    @(posedge clock);
    @(negedge clock);
    req   = 4'b1111;
    len   = 16'h2222;
    reset = 1'b1;

    // ---------------- round-robin with all requests held ----------------
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    ng = 0;
    last_done = -100;
    prev_g = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (grant != 0 && prev_g == 0) begin
        if (ng < 5) check($sformatf("rr_grant%0d", ng), int'(grant), int'(exp_rr[ng]));
        if (ng > 0) check($sformatf("rr_gap%0d", ng), c - last_done, 2);
        ng++;
        if (ng == 5) req = '0;
      end
      if (done != 0) last_done = c;
      prev_g = grant;
      if (ng >= 5 && grant == 0) break;
    end
    check("rr_grant_count", ng, 5);

    // ---------------- request/length change during RUN ----------------
    @(posedge clock); #1;
    req = 4'b1000;
    len = 16'h4000;
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clock);
      if (grant != 0) found = 1'b1;
    end
    check("mid_grant", int'(grant), 4'b1000);
    en = 0; dn = 0; dval = '0;
    for (int c = 0; c < 40 && grant != 0; c++) begin
      if (cnt_enable) begin
        en++;
        if (cnt_value == 4'd1) begin
          req = '0;
          len = 16'h9000;
        end
      end
      if (done != 0) begin
        dn++;
        dval = done;
      end
      @(negedge clock);
    end
    check("mid_enables", en, 4);
    check("mid_done_pulses", dn, 1);
    check("mid_done_bit", int'(dval), 4'b1000);
    check("mid_final_cnt", int'(cnt_value), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
